// File: rtl/reg_file_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp_if
//  Description : Read/write bus bundle for the multi-port register file.
//                master = decode-stage client, slave = register file.
//  Revision    : 1.0  initial release
// ============================================================================
interface reg_file_mp_if #(
   parameter int WIDTH_ADDR = 5,
   parameter int WIDTH_DATA = 32,
   parameter int NUM_RD     = 2
);
   // Packed read ports: port i sits at [i*WIDTH +: WIDTH]
   logic [NUM_RD*WIDTH_ADDR-1:0] rd_addr;
   logic [NUM_RD*WIDTH_DATA-1:0] rd_data;

   // Write port 0
   logic                         wr_en0;
   logic [WIDTH_ADDR-1:0]        wr_addr0;
   logic [WIDTH_DATA-1:0]        wr_data0;

   // Write port 1 (wins on an address collision with port 0)
   logic                         wr_en1;
   logic [WIDTH_ADDR-1:0]        wr_addr1;
   logic [WIDTH_DATA-1:0]        wr_data1;

   // High while the post-reset clear sequence runs
   logic                         busy;

   modport master (
      output rd_addr,
      output wr_en0, wr_addr0, wr_data0,
      output wr_en1, wr_addr1, wr_data1,
      input  rd_data,
      input  busy
   );

   modport slave (
      input  rd_addr,
      input  wr_en0, wr_addr0, wr_data0,
      input  wr_en1, wr_addr1, wr_data1,
      output rd_data,
      output busy
   );
endinterface
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp
//  Description : Parametrised register file with NUM_RD combinational read
//                ports, two write ports, optional hardwired-zero entry 0,
//                optional same-cycle write-to-read bypass and a sequenced
//                hardware clear of every entry after reset.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_file_mp #(
   parameter int WIDTH_ADDR = 5,   // DEPTH = 2**WIDTH_ADDR entries
   parameter int WIDTH_DATA = 32,  // bits per entry
   parameter int NUM_RD     = 2,   // read ports, 1..4
   parameter int ZERO_REG   = 1,   // 1: entry 0 hardwired to zero
   parameter int BYPASS     = 1    // 1: forward same-cycle write data to reads
) (
   input  logic          clk,
   input  logic          rst,
   reg_file_mp_if.slave  bus
);

   localparam int                    c_depth     = 2**WIDTH_ADDR;
   localparam logic [WIDTH_ADDR-1:0] c_last_addr = '1;
   localparam logic [WIDTH_ADDR-1:0] c_addr_zero = '0;
   localparam logic [WIDTH_ADDR-1:0] c_addr_one  = WIDTH_ADDR'(1);
   localparam bit                    c_zero_en   = (ZERO_REG != 0);
   localparam bit                    c_bypass_en = (BYPASS != 0);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                  r_state;
   logic [WIDTH_ADDR-1:0]   r_clr_cnt;
   logic                    r_busy;
   logic [WIDTH_DATA-1:0]   r_regs [c_depth];

   logic                    w_ready;
   logic                    w_wr0_ok;
   logic                    w_wr1_ok;
   logic [WIDTH_ADDR-1:0]   w_port_addr [NUM_RD];
   logic [WIDTH_DATA-1:0]   w_port_data [NUM_RD];
   logic [NUM_RD*WIDTH_DATA-1:0] w_rd_data;

   // A write is live only in READY and, with the zero entry hardwired,
   // only when it does not target address 0.
   assign w_ready  = (r_state == ST_READY);
   assign w_wr0_ok = bus.wr_en0 && w_ready &&
                     !(c_zero_en && (bus.wr_addr0 == c_addr_zero));
   assign w_wr1_ok = bus.wr_en1 && w_ready &&
                     !(c_zero_en && (bus.wr_addr1 == c_addr_zero));

   // Clear sequencer: reset (re)starts the walk at entry 0; the last entry
   // cleared hands over to READY. busy is a flop of its own so the decode
   // stage sees a clean registered stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_CLEAR;
         r_clr_cnt <= '0;
         r_busy    <= 1'b1;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               r_clr_cnt <= r_clr_cnt + c_addr_one;
               if (r_clr_cnt == c_last_addr) begin
                  r_state <= ST_READY;
                  r_busy  <= 1'b0;
               end
            end
            ST_READY: begin
               r_busy <= 1'b0;
            end
            default: begin
               r_state   <= ST_CLEAR;
               r_clr_cnt <= '0;
               r_busy    <= 1'b1;
            end
         endcase
      end
   end

   // Storage: clear walk during CLEAR, otherwise the two write ports.
   // Port 1 is assigned last so it wins when both hit the same entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_regs[0] <= '0;
      end else if (!w_ready) begin
         r_regs[r_clr_cnt] <= '0;
      end else begin
         if (w_wr0_ok) begin
            r_regs[bus.wr_addr0] <= bus.wr_data0;
         end
         if (w_wr1_ok) begin
            r_regs[bus.wr_addr1] <= bus.wr_data1;
         end
      end
   end

   // Combinational read ports. Priority, lowest to highest: stored value,
   // port 0 bypass, port 1 bypass, hardwired zero entry, busy blanking.
   always_comb begin
      w_rd_data = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         w_port_addr[p] = bus.rd_addr[p*WIDTH_ADDR +: WIDTH_ADDR];
         w_port_data[p] = r_regs[w_port_addr[p]];
         if (c_bypass_en) begin
            if (w_wr0_ok && (bus.wr_addr0 == w_port_addr[p])) begin
               w_port_data[p] = bus.wr_data0;
            end
            if (w_wr1_ok && (bus.wr_addr1 == w_port_addr[p])) begin
               w_port_data[p] = bus.wr_data1;
            end
         end
         if (c_zero_en && (w_port_addr[p] == c_addr_zero)) begin
            w_port_data[p] = '0;
         end
         if (r_busy) begin
            w_port_data[p] = '0;
         end
         w_rd_data[p*WIDTH_DATA +: WIDTH_DATA] = w_port_data[p];
      end
   end

   assign bus.rd_data = w_rd_data;
   assign bus.busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_mp
//  Description : Self-checking bench for reg_file_mp. Two instances share one
//                stimulus stream: one with bypass, one without. Directed
//                vectors, clear-sequence corner cases and random traffic are
//                compared against an array-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_file_mp;

   localparam int WA    = 5;
   localparam int WD    = 32;
   localparam int NRD   = 2;
   localparam int DEPTH = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [NRD*WA-1:0] rd_addr;
   logic              en0, en1;
   logic [WA-1:0]     a0, a1;
   logic [WD-1:0]     d0, d1;

   reg_file_mp_if #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD), .NUM_RD(NRD)) bus_bp ();
   reg_file_mp_if #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD), .NUM_RD(NRD)) bus_nb ();

   assign bus_bp.rd_addr  = rd_addr;
   assign bus_bp.wr_en0   = en0;
   assign bus_bp.wr_addr0 = a0;
   assign bus_bp.wr_data0 = d0;
   assign bus_bp.wr_en1   = en1;
   assign bus_bp.wr_addr1 = a1;
   assign bus_bp.wr_data1 = d1;
   assign bus_nb.rd_addr  = rd_addr;
   assign bus_nb.wr_en0   = en0;
   assign bus_nb.wr_addr0 = a0;
   assign bus_nb.wr_data0 = d0;
   assign bus_nb.wr_en1   = en1;
   assign bus_nb.wr_addr1 = a1;
   assign bus_nb.wr_data1 = d1;

   reg_file_mp #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD), .NUM_RD(NRD),
                 .ZERO_REG(1), .BYPASS(1)) dut_bp (
      .clk (clk),
      .rst (rst),
      .bus (bus_bp)
   );

   reg_file_mp #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD), .NUM_RD(NRD),
                 .ZERO_REG(1), .BYPASS(0)) dut_nb (
      .clk (clk),
      .rst (rst),
      .bus (bus_nb)
   );

   // ---------------- reference model ----------------
   logic [WD-1:0] mem [DEPTH];
   bit            m_busy = 1'b1;
   int            m_left = 0;

   int n_checks = 0;
   int n_errors = 0;

   // Committed state changes at one clock edge, from the inputs held there.
   task automatic model_edge();
      if (rst) begin
         m_busy = 1'b1;
         m_left = DEPTH;
      end else if (m_busy) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_busy = 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] = '0;
         end
      end else begin
         if (en0 && a0 != 0) mem[a0] = d0;
         if (en1 && a1 != 0) mem[a1] = d1;
      end
   endtask

   function automatic logic [WD-1:0] exp_rd(input logic [WA-1:0] a, input bit bp);
      if (m_busy || a == 0) return '0;
      if (bp) begin
         if (en1 && a1 == a) return d1;
         if (en0 && a0 == a) return d0;
      end
      return mem[a];
   endfunction

   task automatic check(input string name, input logic [WD-1:0] got,
                        input logic [WD-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [WA-1:0] a;
      for (int p = 0; p < NRD; p++) begin
         a = rd_addr[p*WA +: WA];
         check($sformatf("%s bp port%0d addr%0d", tag, p, a),
               bus_bp.rd_data[p*WD +: WD], exp_rd(a, 1'b1));
         check($sformatf("%s nb port%0d addr%0d", tag, p, a),
               bus_nb.rd_data[p*WD +: WD], exp_rd(a, 1'b0));
      end
      check({tag, " busy bp"}, 32'(bus_bp.busy), 32'(m_busy));
      check({tag, " busy nb"}, 32'(bus_nb.busy), 32'(m_busy));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_idle();
      rst = 1'b0;
      en0 = 1'b0; a0 = '0; d0 = '0;
      en1 = 1'b0; a1 = '0; d1 = '0;
      rd_addr = '0;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic          en0;
      logic [WA-1:0] a0;
      logic [WD-1:0] d0;
      logic          en1;
      logic [WA-1:0] a1;
      logic [WD-1:0] d1;
      logic [WA-1:0] r0;
      logic [WA-1:0] r1;
      logic [WD-1:0] x0;    // bypass instance, port 0, same cycle
      logic [WD-1:0] x1;    // bypass instance, port 1, same cycle
      logic [WD-1:0] xnb0;  // non-bypass instance, port 0, same cycle
   } vec_t;

   vec_t vecs [10];

   initial begin
      int cnt;

      vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,
                  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0};
      vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,
                  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0};
      vecs[2] = '{1'b1, 5'd7,  32'h11111111, 1'b1, 5'd7,  32'h22222222,
                  5'd7,  5'd7,  32'h22222222, 32'h22222222, 32'h0};
      vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,
                  5'd7,  5'd5,  32'h22222222, 32'hDEADBEEF, 32'h22222222};
      vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFFFFFF,
                  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
      vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,
                  5'd0,  5'd7,  32'h0,        32'h22222222, 32'h0};
      vecs[6] = '{1'b1, 5'd3,  32'hA5A5A5A5, 1'b0, 5'd0,  32'h0,
                  5'd3,  5'd3,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0};
      vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,
                  5'd3,  5'd3,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
      vecs[8] = '{1'b1, 5'd9,  32'h12345678, 1'b1, 5'd10, 32'h9ABCDEF0,
                  5'd10, 5'd9,  32'h9ABCDEF0, 32'h12345678, 32'h0};
      vecs[9] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,
                  5'd9,  5'd10, 32'h12345678, 32'h9ABCDEF0, 32'h12345678};

      set_idle();
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      #2;

      // ---- reset, then clear lasting exactly DEPTH edges ----
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("busy after rst", 32'(bus_bp.busy), 32'd1);
      cnt = 0;
      while (bus_bp.busy && cnt < 40) begin
         rd_addr = NRD*WA'($urandom);
         #1;
         check_all("clear");
         tick();
         cnt++;
      end
      check("clear length", 32'(cnt), 32'(DEPTH));

      // ---- every entry reads zero after the clear ----
      for (int e = 0; e < DEPTH; e++) begin
         rd_addr[WA-1:0]    = WA'(e);
         rd_addr[2*WA-1:WA] = WA'(DEPTH - 1 - e);
         #1;
         check($sformatf("post-clear entry %0d", e), bus_bp.rd_data[WD-1:0], 32'h0);
         tick();
      end

      // ---- table-driven directed vectors ----
      for (int v = 0; v < 10; v++) begin
         en0 = vecs[v].en0; a0 = vecs[v].a0; d0 = vecs[v].d0;
         en1 = vecs[v].en1; a1 = vecs[v].a1; d1 = vecs[v].d1;
         rd_addr = {vecs[v].r1, vecs[v].r0};
         #1;
         check($sformatf("vec%0d bp port0", v), bus_bp.rd_data[WD-1:0],    vecs[v].x0);
         check($sformatf("vec%0d bp port1", v), bus_bp.rd_data[2*WD-1:WD], vecs[v].x1);
         check($sformatf("vec%0d nb port0", v), bus_nb.rd_data[WD-1:0],    vecs[v].xnb0);
         check_all($sformatf("vec%0d", v));
         tick();
         set_idle();
      end

      // ---- reset again mid-clear, with a write held during the clear ----
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (10) begin
         rd_addr = {5'd7, 5'd5};
         #1;
         check_all("pre-restart");
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      en0 = 1'b1; a0 = 5'd5; d0 = 32'hCAFEF00D;
      rd_addr = {5'd7, 5'd5};
      cnt = 0;
      while (bus_bp.busy && cnt < 40) begin
         #1;
         check_all("restart clear");
         tick();
         cnt++;
      end
      check("restart clear length", 32'(cnt), 32'(DEPTH));
      set_idle();
      rd_addr = {5'd7, 5'd5};
      #1;
      check("write during clear dropped", bus_bp.rd_data[WD-1:0],    32'h0);
      check("entry 7 cleared",            bus_bp.rd_data[2*WD-1:WD], 32'h0);
      tick();

      // ---- random traffic against the model ----
      for (int c = 0; c < 500; c++) begin
         rst = ($urandom_range(0, 249) == 0);
         en0 = $urandom_range(0, 1) == 1;
         en1 = $urandom_range(0, 1) == 1;
         a0  = ($urandom_range(0, 1) == 1) ? WA'($urandom_range(0, 7)) : WA'($urandom);
         a1  = ($urandom_range(0, 1) == 1) ? WA'($urandom_range(0, 7)) : WA'($urandom);
         d0  = $urandom;
         d1  = $urandom;
         for (int p = 0; p < NRD; p++) begin
            case ($urandom_range(0, 3))
               0:       rd_addr[p*WA +: WA] = a0;
               1:       rd_addr[p*WA +: WA] = a1;
               2:       rd_addr[p*WA +: WA] = WA'($urandom_range(0, 7));
               default: rd_addr[p*WA +: WA] = WA'($urandom);
            endcase
         end
         #1;
         check_all("random");
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
